// File: rtl/code_selection_top.sv
// code_selection_top: priority-based ownership arbiter for five shared objects.
// Each object keeps a busy flag and a 3-bit owner level, packed directly onto status_o.
module code_selection_top (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  lp_i,
    input  logic [2:0]  object_number_i,
    input  logic        command_i,
    input  logic        en_i,
    output logic [19:0] status_o
);
    logic valid;

    assign valid = en_i && (lp_i != 3'd0) && (object_number_i <= 3'd4);

    // status_o is the state register itself: nibble k holds {busy, owner} of object k
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            status_o <= '0;
        else if (valid)
            for (int k = 0; k < 5; k++)
                if (object_number_i == 3'(k)) begin
                    if (command_i && (!status_o[4*k+3] || lp_i > status_o[4*k +: 3]))
                        status_o[4*k +: 4] <= {1'b1, lp_i};
                    else if (!command_i && status_o[4*k+3] && status_o[4*k +: 3] == lp_i)
                        status_o[4*k +: 4] <= 4'h0;
                end
    end
endmodule

// File: tb/tb_code_selection_top.sv
// tb_code_selection_top: directed vector table plus randomized soak against an ownership model.
module tb_code_selection_top;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [2:0]  lp_i = '0;
    logic [2:0]  object_number_i = '0;
    logic        command_i = 1'b0;
    logic        en_i = 1'b0;
    logic [19:0] status_o;

    int passed = 0;
    int total = 0;
    int own [5];

    code_selection_top dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .lp_i(lp_i),
        .object_number_i(object_number_i),
        .command_i(command_i),
        .en_i(en_i),
        .status_o(status_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  lp;
        logic [2:0]  obj;
        logic        cmd;
        logic        en;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %05h expected %05h", name, act, exp);
    endtask

    function automatic logic [19:0] model_status();
        logic [19:0] s = '0;
        for (int k = 0; k < 5; k++)
            if (own[k] != 0) s[4*k +: 4] = {1'b1, 3'(own[k])};
        return s;
    endfunction

    function automatic void model_step(int lp, int obj, bit cmd, bit en);
        if (!en || lp == 0 || obj > 4) return;
        if (cmd) begin
            if (lp > own[obj]) own[obj] = lp;
        end else if (own[obj] == lp) begin
            own[obj] = 0;
        end
    endfunction

    task automatic randomize_inputs(input int lp_max, input int obj_max);
        lp_i = 3'($urandom_range(lp_max, 0));
        object_number_i = 3'($urandom_range(obj_max, 0));
        command_i = 1'($urandom_range(1, 0));
        en_i = 1'($urandom_range(1, 0));
    endtask

    initial begin
        bit inv_ok;
        vecs[0]  = '{3'd2, 3'd3, 1'b1, 1'b1, 20'h0A000};
        vecs[1]  = '{3'd1, 3'd3, 1'b1, 1'b1, 20'h0A000};
        vecs[2]  = '{3'd3, 3'd3, 1'b1, 1'b1, 20'h0B000};
        vecs[3]  = '{3'd2, 3'd3, 1'b0, 1'b1, 20'h0B000};
        vecs[4]  = '{3'd3, 3'd3, 1'b0, 1'b1, 20'h00000};
        vecs[5]  = '{3'd4, 3'd0, 1'b1, 1'b1, 20'h0000C};
        vecs[6]  = '{3'd4, 3'd5, 1'b0, 1'b1, 20'h0000C};
        vecs[7]  = '{3'd7, 3'd6, 1'b1, 1'b1, 20'h0000C};
        vecs[8]  = '{3'd7, 3'd7, 1'b1, 1'b1, 20'h0000C};
        vecs[9]  = '{3'd0, 3'd0, 1'b1, 1'b1, 20'h0000C};
        vecs[10] = '{3'd0, 3'd0, 1'b0, 1'b1, 20'h0000C};
        vecs[11] = '{3'd7, 3'd0, 1'b1, 1'b0, 20'h0000C};
        vecs[12] = '{3'd4, 3'd0, 1'b0, 1'b0, 20'h0000C};
        vecs[13] = '{3'd4, 3'd0, 1'b1, 1'b1, 20'h0000C};
        vecs[14] = '{3'd7, 3'd4, 1'b1, 1'b1, 20'hF000C};
        vecs[15] = '{3'd4, 3'd0, 1'b0, 1'b1, 20'hF0000};
        vecs[16] = '{3'd6, 3'd4, 1'b0, 1'b1, 20'hF0000};
        vecs[17] = '{3'd7, 3'd4, 1'b0, 1'b1, 20'h00000};
        vecs[18] = '{3'd1, 3'd1, 1'b0, 1'b1, 20'h00000};
        vecs[19] = '{3'd5, 3'd2, 1'b1, 1'b1, 20'h00500 | 20'h00800};

        // reset held low with random request traffic
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            randomize_inputs(7, 7);
            en_i = 1'b1;
            @(negedge clk_i);
            chk("reset_hold", status_o, 20'h00000);
        end
        en_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("reset_release_idle", status_o, 20'h00000);

        foreach (vecs[i]) begin
            lp_i = vecs[i].lp;
            object_number_i = vecs[i].obj;
            command_i = vecs[i].cmd;
            en_i = vecs[i].en;
            @(negedge clk_i);
            chk($sformatf("vec%0d", i), status_o, vecs[i].exp);
        end

        // release object 2 so the soak starts from an all-free state
        lp_i = 3'd5; object_number_i = 3'd2; command_i = 1'b0; en_i = 1'b1;
        @(negedge clk_i);
        chk("release_obj2", status_o, 20'h00000);
        foreach (own[k]) own[k] = 0;

        for (int c = 0; c < 2500; c++) begin
            if (c == 1200) begin
                #2 rst_i = 1'b0;
                #1 chk("async_reset", status_o, 20'h00000);
                foreach (own[k]) own[k] = 0;
                @(negedge clk_i);
                chk("reset_held_soak", status_o, 20'h00000);
                rst_i = 1'b1;
            end
            randomize_inputs(3, 4);
            model_step(int'(lp_i), int'(object_number_i), command_i, en_i);
            @(negedge clk_i);
            chk($sformatf("soak%0d", c), status_o, model_status());
            inv_ok = 1'b1;
            for (int k = 0; k < 5; k++)
                if (status_o[4*k+3] != (status_o[4*k +: 3] != 3'd0)) inv_ok = 1'b0;
            total++;
            if (inv_ok) passed++;
            else $display("FAIL invariant%0d: status %05h violates busy/owner pairing", c, status_o);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
